// File: rtl/spectrum_peak_search_pkg.sv
// Shared definitions for the spectrum peak search block.
//   - Scan geometry and magnitude width constants
//   - Scan FSM state encoding
//   - Peak record type and an empty-record constant
//   - bin_dist(): absolute distance between two bin indices
package spec_pkg;

  localparam int NUM_BINS = 128;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 16;
  localparam int RD_LAT   = 1;
  localparam int THRESH   = 64;
  localparam int MIN_SEP  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] bin;
    logic [DATA_W-1:0] mag;
    logic              valid;
  } peak_t;

  localparam peak_t PEAK_EMPTY = '0;

  function automatic logic [ADDR_W-1:0] bin_dist(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/peak_top2_tracker.sv
// Keeps the two largest accepted peak candidates of a scan.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clear          empties both entries (start of a new scan)
//   cand_vld       a candidate is presented this cycle
//   cand_bin/mag   candidate bin index and magnitude
//   p1, p2         largest and second-largest peaks (empty = all zero)
module peak_top2_tracker
  import spec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              cand_vld,
  input  logic [ADDR_W-1:0] cand_bin,
  input  logic [DATA_W-1:0] cand_mag,
  output peak_t             p1,
  output peak_t             p2
);

  peak_t p1_q, p1_d;
  peak_t p2_q, p2_d;
  peak_t cand;
  logic  sep_ok;
  logic  beats_p1;
  logic  beats_p2;

  always_comb begin
    p1_d     = p1_q;
    p2_d     = p2_q;
    cand     = '{bin: cand_bin, mag: cand_mag, valid: 1'b1};
    sep_ok   = bin_dist(cand_bin, p1_q.bin) >= ADDR_W'(MIN_SEP);
    // Strict comparisons: on equal magnitude the earlier bin keeps its place.
    beats_p1 = !p1_q.valid || (cand_mag > p1_q.mag);
    beats_p2 = !p2_q.valid || (cand_mag > p2_q.mag);
    if (clear) begin
      p1_d = PEAK_EMPTY;
      p2_d = PEAK_EMPTY;
    end else if (cand_vld) begin
      if (beats_p1) begin
        // A stronger candidate sitting next to p1 replaces it without
        // demoting it, so a single broad tone never fills both slots.
        if (sep_ok || !p1_q.valid) p2_d = p1_q;
        p1_d = cand;
      end else if (beats_p2 && sep_ok) begin
        p2_d = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q <= PEAK_EMPTY;
      p2_q <= PEAK_EMPTY;
    end else begin
      p1_q <= p1_d;
      p2_q <= p2_d;
    end
  end

  assign p1 = p1_q;
  assign p2 = p2_q;

endmodule

// File: rtl/spectrum_peak_search.sv
// Scans the FFT magnitude RAM once per rising edge of start and reports the
// two strongest local maxima above THRESH (DC and last bin excluded).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                write-done level; a rising edge starts one scan
//   rd_en, rd_addr       RAM read request, addresses 0..NUM_BINS-1
//   rd_data              RAM data, valid RD_LAT cycles after rd_en
//   busy                 high from scan start until done
//   done                 one-cycle pulse, result outputs updated
//   peak_cnt             number of peaks found (0..2)
//   peak1_bin/mag        largest peak
//   peak2_bin/mag        second peak
module spectrum_peak_search
  import spec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        peak_cnt,
  output logic [ADDR_W-1:0] peak1_bin,
  output logic [DATA_W-1:0] peak1_mag,
  output logic [ADDR_W-1:0] peak2_bin,
  output logic [DATA_W-1:0] peak2_mag
);

  localparam int DRAIN_W = $clog2(RD_LAT + 2);

  // Control state
  state_e              state_q, state_d;
  logic                start_q;
  logic                start_arm_q, start_arm_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [1:0]          peak_cnt_q, peak_cnt_d;
  logic [ADDR_W-1:0]   peak1_bin_q, peak1_bin_d, peak2_bin_q, peak2_bin_d;
  logic [DATA_W-1:0]   peak1_mag_q, peak1_mag_d, peak2_mag_q, peak2_mag_d;
  logic                start_edge;
  logic                scan_start;

  // Read-return and window pipeline
  logic [RD_LAT-1:0]   rd_vld_q, rd_vld_d;
  logic                samp_vld;
  logic [ADDR_W-1:0]   samp_idx_q, samp_idx_d;
  logic                win_vld_q, win_vld_d;
  logic [ADDR_W-1:0]   cand_bin_q, cand_bin_d;
  logic [DATA_W-1:0]   m_q [3];
  logic [DATA_W-1:0]   m_d [3];
  logic                cand_vld;
  peak_t               p1, p2;

  // An edge only counts once start has been seen low since reset, so a
  // write-done level still high across a reset does not retrigger a scan.
  assign start_edge = start & ~start_q & start_arm_q;

  always_comb begin
    state_d     = state_q;
    start_arm_d = start_arm_q | ~start;
    rd_en_d     = rd_en_q;
    rd_addr_d   = rd_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    drain_cnt_d = drain_cnt_q;
    peak_cnt_d  = peak_cnt_q;
    peak1_bin_d = peak1_bin_q;
    peak1_mag_d = peak1_mag_q;
    peak2_bin_d = peak2_bin_q;
    peak2_mag_d = peak2_mag_q;
    scan_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        if (start_edge) begin
          scan_start = 1'b1;
          busy_d     = 1'b1;
          rd_en_d    = 1'b1;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        if (rd_addr_q == ADDR_W'(NUM_BINS - 1)) begin
          rd_en_d     = 1'b0;
          rd_addr_d   = '0;
          drain_cnt_d = '0;
          state_d     = ST_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // RD_LAT cycles for the last word plus one cycle to evaluate it.
        if (drain_cnt_q == DRAIN_W'(RD_LAT)) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        peak_cnt_d  = {1'b0, p1.valid} + {1'b0, p2.valid};
        peak1_bin_d = p1.bin;
        peak1_mag_d = p1.mag;
        peak2_bin_d = p2.bin;
        peak2_mag_d = p2.mag;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      start_arm_q <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drain_cnt_q <= '0;
      peak_cnt_q  <= '0;
      peak1_bin_q <= '0;
      peak1_mag_q <= '0;
      peak2_bin_q <= '0;
      peak2_mag_q <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      start_arm_q <= start_arm_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      drain_cnt_q <= drain_cnt_d;
      peak_cnt_q  <= peak_cnt_d;
      peak1_bin_q <= peak1_bin_d;
      peak1_mag_q <= peak1_mag_d;
      peak2_bin_q <= peak2_bin_d;
      peak2_mag_q <= peak2_mag_d;
    end
  end

  // Read return: rd_en delayed by RD_LAT marks valid rd_data
  always_comb begin
    rd_vld_d[0] = rd_en_q;
    for (int i = 1; i < RD_LAT; i++) rd_vld_d[i] = rd_vld_q[i-1];
  end

  assign samp_vld = rd_vld_q[RD_LAT-1];

  // Window shift: m[0]=m[k-1], m[1]=m[k], m[2]=m[k+1]
  always_comb begin
    samp_idx_d = samp_idx_q;
    if (scan_start)    samp_idx_d = '0;
    else if (samp_vld) samp_idx_d = samp_idx_q + 1'b1;
    // Centre k = newest-1 is valid once samples 0..2 are in, which keeps
    // bin 0 and the last bin out of the candidate set.
    win_vld_d  = samp_vld && (samp_idx_q >= ADDR_W'(2));
    cand_bin_d = samp_vld ? (samp_idx_q - 1'b1) : cand_bin_q;
    m_d[0]     = samp_vld ? m_q[1]  : m_q[0];
    m_d[1]     = samp_vld ? m_q[2]  : m_q[1];
    m_d[2]     = samp_vld ? rd_data : m_q[2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q   <= '0;
      samp_idx_q <= '0;
      win_vld_q  <= 1'b0;
    end else begin
      rd_vld_q   <= rd_vld_d;
      samp_idx_q <= samp_idx_d;
      win_vld_q  <= win_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    cand_bin_q <= cand_bin_d;
    m_q        <= m_d;
  end

  // Candidate evaluation: strict left compare makes plateaus report leftmost
  assign cand_vld = win_vld_q && (m_q[1] > m_q[0]) && (m_q[1] >= m_q[2]) &&
                    (m_q[1] >= DATA_W'(THRESH));

  peak_top2_tracker u_tracker (
    .clk      (clk),
    .rst      (rst),
    .clear    (scan_start),
    .cand_vld (cand_vld),
    .cand_bin (cand_bin_q),
    .cand_mag (m_q[1]),
    .p1       (p1),
    .p2       (p2)
  );

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign peak_cnt  = peak_cnt_q;
  assign peak1_bin = peak1_bin_q;
  assign peak1_mag = peak1_mag_q;
  assign peak2_bin = peak2_bin_q;
  assign peak2_mag = peak2_mag_q;

endmodule

// File: tb/tb_spectrum_peak_search.sv
module tb_spectrum_peak_search;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data = '0;
  logic        busy;
  logic        done;
  logic [1:0]  peak_cnt;
  logic [7:0]  peak1_bin;
  logic [15:0] peak1_mag;
  logic [7:0]  peak2_bin;
  logic [15:0] peak2_mag;

  logic [15:0] mem [0:127];

  int errors = 0;
  int checks = 0;

  int         rd_cnt = 0;
  int         addr_err = 0;
  int         done_cnt = 0;
  logic       rd_en_prev = 1'b0;
  logic [7:0] last_addr = '0;
  logic [1:0] mid_cnt;

  always #5 clk = ~clk;

  spectrum_peak_search dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .peak_cnt  (peak_cnt),
    .peak1_bin (peak1_bin),
    .peak1_mag (peak1_mag),
    .peak2_bin (peak2_bin),
    .peak2_mag (peak2_mag)
  );

  // Magnitude RAM, one cycle read latency
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Read-port monitor: counts reads, checks addresses run 0,1,2,... per burst
  always @(negedge clk) begin
    rd_en_prev <= rd_en;
    if (done) done_cnt <= done_cnt + 1;
    if (rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (rd_addr != (rd_en_prev ? last_addr + 8'd1 : 8'd0)) addr_err <= addr_err + 1;
      last_addr <= rd_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic fill_mem(input logic [15:0] val);
    for (int i = 0; i < 128; i++) mem[i] = val;
  endtask

  task automatic do_scan(input string tag);
    int   c0, a0, lat;
    logic busy_seen, busy_at_done, done_next;
    c0 = rd_cnt;
    a0 = addr_err;
    lat = 0;
    busy_seen = 1'b0;
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);  // edge sampled here
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (n == 1)  busy_seen = busy;
      if (n == 60) mid_cnt = peak_cnt;
      if (done) begin
        lat = n;
        break;
      end
    end
    busy_at_done = busy;
    @(posedge clk); #1;
    done_next = done;
    check({tag, ".latency"},   lat,          131);
    check({tag, ".busy_scan"}, busy_seen,    1);
    check({tag, ".busy_done"}, busy_at_done, 0);
    check({tag, ".done_1cyc"}, done_next,    0);
    check({tag, ".rd_cnt"},    rd_cnt - c0,  128);
    check({tag, ".addr_seq"},  addr_err - a0, 0);
  endtask

  task automatic check_res(input string tag, input int cnt,
                           input int b1, input int m1, input int b2, input int m2);
    check({tag, ".cnt"},   peak_cnt,  cnt);
    check({tag, ".p1bin"}, peak1_bin, b1);
    check({tag, ".p1mag"}, peak1_mag, m1);
    check({tag, ".p2bin"}, peak2_bin, b2);
    check({tag, ".p2mag"}, peak2_mag, m2);
  endtask

  initial begin
    int d0, r0;
    rst = 1'b1;
    start = 1'b0;
    fill_mem(16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset.rd_en",   rd_en,   0);
    check("reset.rd_addr", rd_addr, 0);
    check("reset.busy",    busy,    0);
    check("reset.done",    done,    0);
    check_res("reset", 0, 0, 0, 0, 0);

    // All-zero spectrum
    do_scan("zero");
    check_res("zero", 0, 0, 0, 0, 0);

    // Single tone with skirts
    fill_mem(16'd10);
    mem[19] = 16'd500; mem[20] = 16'd1000; mem[21] = 16'd500;
    do_scan("tone1");
    check_res("tone1", 1, 20, 1000, 0, 0);

    // Two tones, stronger one later
    fill_mem(16'd10);
    mem[10] = 16'd800; mem[50] = 16'd1200;
    do_scan("tone2");
    check_res("tone2", 2, 50, 1200, 10, 800);

    // DC, last bin and sub-threshold bins rejected
    fill_mem(16'd0);
    mem[0] = 16'd5000; mem[127] = 16'd4000; mem[30] = 16'd300; mem[40] = 16'd50;
    do_scan("edges");
    check_res("edges", 1, 30, 300, 0, 0);

    // Equal magnitudes: earlier bin ranks first
    fill_mem(16'd0);
    mem[15] = 16'd900; mem[60] = 16'd900;
    do_scan("equal");
    check_res("equal", 2, 15, 900, 60, 900);

    // Weaker candidate too close to p1 discarded; previous results held mid-scan
    fill_mem(16'd0);
    mem[40] = 16'd900; mem[42] = 16'd700;
    do_scan("close");
    check("close.held_mid", mid_cnt, 2);
    check_res("close", 1, 40, 900, 0, 0);

    // Stronger candidate too close to p1 replaces it, p2 stays empty
    fill_mem(16'd0);
    mem[40] = 16'd700; mem[42] = 16'd900;
    do_scan("replace");
    check_res("replace", 1, 42, 900, 0, 0);

    // Plateau reports leftmost bin
    fill_mem(16'd0);
    mem[70] = 16'd500; mem[71] = 16'd500;
    do_scan("plateau");
    check_res("plateau", 1, 70, 500, 0, 0);

    // Reset 40 cycles into a scan, start held high afterwards
    fill_mem(16'd10);
    mem[10] = 16'd800; mem[50] = 16'd1200;
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    repeat (40) @(negedge clk);
    check("abort.busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.rd_en", rd_en, 0);
    check("abort.busy",  busy,  0);
    check("abort.done",  done,  0);
    check_res("abort", 0, 0, 0, 0, 0);
    d0 = done_cnt;
    r0 = rd_cnt;
    repeat (200) @(negedge clk);
    check("abort.no_done", done_cnt - d0, 0);
    check("abort.no_read", rd_cnt - r0,   0);

    // Fresh edge after reset runs a full scan
    do_scan("rearm");
    check_res("rearm", 2, 50, 1200, 10, 800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
